// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer
// Drives the board LED through ON/OFF phases measured in prescaler ticks.
// The phases repeat for a commanded number of cycles, or run until abort when
// the repeat count is 0. A host hands over one pattern at a time through a
// valid/ready handshake. The sequencer only accepts a command while idle.

module led_blink_sequencer #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned REP_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [DUR_W-1:0] i_on_ticks,
    input  logic [DUR_W-1:0] i_off_ticks,
    input  logic [REP_W-1:0] i_repeat,
    input  logic             i_abort,
    output logic             o_led,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tick
);

    localparam int unsigned        PRESC_W    = 27;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]   DUR_ONE    = DUR_W'(1);
    localparam logic [REP_W-1:0]   REP_ONE    = REP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic               tick_q,    tick_d;
    logic [DUR_W-1:0]   on_len_q,  on_len_d;
    logic [DUR_W-1:0]   off_len_q, off_len_d;
    logic [DUR_W-1:0]   phase_q,   phase_d;
    logic [REP_W-1:0]   rep_q,     rep_d;
    logic               led_q,     led_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               tick_evt;
    logic               cmd_fire;
    logic [DUR_W-1:0]   on_eff;
    logic [DUR_W-1:0]   off_eff;

    // Handshake decode and zero-to-one clamping of the requested durations
    always_comb begin
        o_cmd_ready = (state_q == ST_IDLE) && !i_abort;
        cmd_fire    = i_cmd_valid && o_cmd_ready;
        tick_evt    = (presc_q == PRESC_LAST);
        on_eff      = (i_on_ticks  == '0) ? DUR_ONE : i_on_ticks;
        off_eff     = (i_off_ticks == '0) ? DUR_ONE : i_off_ticks;
    end

    // Prescaler: free-running divider, restarted on accept so that the first
    // ON phase is a whole number of ticks long
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        tick_d  = tick_evt;
        if (cmd_fire || tick_evt) begin
            presc_d = '0;
        end
    end

    // Sequencer next-state: phase and repeat countdown, abort has priority
    always_comb begin
        state_d   = state_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        phase_d   = phase_q;
        rep_d     = rep_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    on_len_d  = on_eff;
                    off_len_d = off_eff;
                    phase_d   = on_eff;
                    rep_d     = i_repeat;
                    state_d   = ST_ON;
                end
            end

            ST_ON: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (tick_evt) begin
                    if (phase_q == DUR_ONE) begin
                        state_d = ST_OFF;
                        phase_d = off_len_q;
                    end else begin
                        phase_d = phase_q - DUR_ONE;
                    end
                end
            end

            ST_OFF: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (tick_evt) begin
                    if (phase_q == DUR_ONE) begin
                        if (rep_q == REP_ONE) begin
                            // Natural end of the last cycle
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            // rep_q == 0 means endless; never decrement it
                            if (rep_q != '0) begin
                                rep_d = rep_q - REP_ONE;
                            end
                            state_d = ST_ON;
                            phase_d = on_len_q;
                        end
                    end else begin
                        phase_d = phase_q - DUR_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered LED drive and status, derived from the upcoming state
    always_comb begin
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            on_len_q  <= '0;
            off_len_q <= '0;
            phase_q   <= '0;
            rep_q     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            phase_q   <= phase_d;
            rep_q     <= rep_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_led  = led_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_tick = tick_q;

endmodule
